// File: rtl/orv64_sysbus_rd_arb.sv
// orv64_sysbus_rd_arb: shares one sysbus AR/R port among NUM_REQ read requesters.
// Latency: 0 cycles on AR (comb select) and on R (comb route by rid tag).
// Backpressure: a stalled AR grant is locked in ST_HOLD until arready; rready follows the addressed requester.
//
// Ports:
//   clk_i, rst_n_i                  clock, synchronous active-low reset
//   req_arvalid_i/req_ar_i          per-requester AR channel in, req_arready_o back
//   req_rvalid_o/req_r_o            per-requester R channel out, req_rready_i back
//   sysbus_req_if_ar*               shared downstream AR channel (arid tagged with requester index)
//   sysbus_resp_if_r*               shared downstream R channel (routed by rid tag)
//   err_bad_rid_o                   sticky: an R beat carried a tag >= NUM_REQ

package orv64_sysbus_pkg;
  localparam int RING_TID_W = 6;
  typedef logic [RING_TID_W-1:0] ring_tid_t;

  typedef struct packed {
    ring_tid_t   arid;
    logic [39:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
  } oursring_req_if_ar_t;

  typedef struct packed {
    ring_tid_t   rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } oursring_resp_if_r_t;
endpackage

module orv64_sysbus_rd_arb
  import orv64_sysbus_pkg::*;
#(
  parameter int NUM_REQ  = 2,  // 2..4
  parameter int MAX_OUTS = 4   // 1..15
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                [NUM_REQ-1:0]   req_arvalid_i,
  input  oursring_req_if_ar_t [NUM_REQ-1:0]   req_ar_i,
  output logic                [NUM_REQ-1:0]   req_arready_o,
  output logic                [NUM_REQ-1:0]   req_rvalid_o,
  output oursring_resp_if_r_t [NUM_REQ-1:0]   req_r_o,
  input  logic                [NUM_REQ-1:0]   req_rready_i,
  output logic                                sysbus_req_if_arvalid_o,
  output oursring_req_if_ar_t                 sysbus_req_if_ar_o,
  input  logic                                sysbus_req_if_arready_i,
  input  logic                                sysbus_resp_if_rvalid_i,
  input  oursring_resp_if_r_t                 sysbus_resp_if_r_i,
  output logic                                sysbus_resp_if_rready_o,
  output logic                                err_bad_rid_o
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int PW      = IDX_W + 1;           // room for ptr+offset before wrap
  localparam int CNT_W   = $clog2(MAX_OUTS + 1);
  localparam int TAG_LSB = RING_TID_W - IDX_W;

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e             rff_state_q;
  logic [IDX_W-1:0]   rff_gnt_q;
  logic [IDX_W-1:0]   rff_rr_ptr_q;
  logic [CNT_W-1:0]   outs_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   outs_cnt_d [NUM_REQ];
  logic               err_bad_rid_q;

  logic [NUM_REQ-1:0] elig;
  logic [PW-1:0]      cand;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic               cur_vld;
  logic [IDX_W-1:0]   cur_idx;
  logic               ar_hs;
  oursring_req_if_ar_t ar_mux;

  logic [IDX_W-1:0]   r_tag;
  logic               r_tag_ok;
  logic               r_hs;
  oursring_resp_if_r_t r_clr;
  logic [NUM_REQ-1:0] cnt_inc;
  logic [NUM_REQ-1:0] cnt_dec;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // ---------------- AR arbitration ----------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_arvalid_i[i] && (outs_cnt_q[i] < CNT_W'(MAX_OUTS));
    end
  end

  // Walk offsets from the far end down to 0 so the smallest offset from the
  // round-robin pointer is the one that sticks.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rff_rr_ptr_q} + PW'(k);
      if (cand >= PW'(NUM_REQ)) cand = cand - PW'(NUM_REQ);
      if (elig[cand[IDX_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[IDX_W-1:0];
      end
    end
  end

  // In ST_HOLD the locked grant is presented without re-checking eligibility
  // so arvalid/payload stay stable until the downstream accepts.
  assign cur_vld = (rff_state_q == ST_HOLD) || sel_vld;
  assign cur_idx = (rff_state_q == ST_HOLD) ? rff_gnt_q : sel_idx;

  assign sysbus_req_if_arvalid_o = rst_n_i && cur_vld;
  assign ar_hs = sysbus_req_if_arvalid_o && sysbus_req_if_arready_i;

  always_comb begin
    ar_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cur_idx == IDX_W'(i)) ar_mux = req_ar_i[i];
    end
    sysbus_req_if_ar_o = ar_mux;
    sysbus_req_if_ar_o.arid[TAG_LSB +: IDX_W] = cur_idx;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arready_o[i] = ar_hs && (cur_idx == IDX_W'(i));
    end
  end

  // ---------------- R routing ----------------
  assign r_tag    = sysbus_resp_if_r_i.rid[TAG_LSB +: IDX_W];
  assign r_tag_ok = ({1'b0, r_tag} < PW'(NUM_REQ));

  // Unknown tags are sunk (rready=1) so a stray beat cannot wedge the bus.
  always_comb begin
    r_clr = sysbus_resp_if_r_i;
    r_clr.rid[TAG_LSB +: IDX_W] = '0;
    sysbus_resp_if_rready_o = !r_tag_ok;
    req_rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_r_o[i] = r_clr;
      if (r_tag_ok && (r_tag == IDX_W'(i))) begin
        sysbus_resp_if_rready_o = req_rready_i[i];
        req_rvalid_o[i]         = sysbus_resp_if_rvalid_i && rst_n_i;
      end
    end
  end

  assign r_hs = sysbus_resp_if_rvalid_i && sysbus_resp_if_rready_o;

  // ---------------- outstanding counters ----------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i]    = ar_hs && (cur_idx == IDX_W'(i));
      cnt_dec[i]    = r_hs && r_tag_ok && (r_tag == IDX_W'(i));
      outs_cnt_d[i] = outs_cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        outs_cnt_d[i] = outs_cnt_q[i] + 1'b1;
      end else if (cnt_dec[i] && !cnt_inc[i] && (outs_cnt_q[i] != '0)) begin
        // Saturate at 0: an unmatched R beat must not wrap the count.
        outs_cnt_d[i] = outs_cnt_q[i] - 1'b1;
      end
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rff_state_q   <= ST_IDLE;
      rff_gnt_q     <= '0;
      rff_rr_ptr_q  <= '0;
      err_bad_rid_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) outs_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) outs_cnt_q[i] <= outs_cnt_d[i];
      if (sysbus_resp_if_rvalid_i && !r_tag_ok) err_bad_rid_q <= 1'b1;
      case (rff_state_q)
        ST_IDLE: begin
          if (sel_vld) begin
            if (sysbus_req_if_arready_i) begin
              rff_rr_ptr_q <= ptr_after(sel_idx);
            end else begin
              rff_gnt_q   <= sel_idx;
              rff_state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (sysbus_req_if_arready_i) begin
            rff_rr_ptr_q <= ptr_after(rff_gnt_q);
            rff_state_q  <= ST_IDLE;
          end
        end
        default: rff_state_q <= ST_IDLE;
      endcase
    end
  end

  assign err_bad_rid_o = err_bad_rid_q;

endmodule

// File: tb/tb_orv64_sysbus_rd_arb.sv
// Bench for orv64_sysbus_rd_arb (NUM_REQ=3, MAX_OUTS=4): directed scenarios with
// literal expectations, then randomized traffic, all shadowed by a per-cycle
// behavioural model (grant queue order, outstanding tallies, sticky error).

module tb_orv64_sysbus_rd_arb;
  import orv64_sysbus_pkg::*;

  localparam int N  = 3;
  localparam int MO = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                [N-1:0] req_arvalid;
  oursring_req_if_ar_t [N-1:0] req_ar;
  logic                [N-1:0] req_arready;
  logic                [N-1:0] req_rvalid;
  oursring_resp_if_r_t [N-1:0] req_r;
  logic                [N-1:0] req_rready;
  logic                        sb_arvalid;
  oursring_req_if_ar_t         sb_ar;
  logic                        sb_arready;
  logic                        sb_rvalid;
  oursring_resp_if_r_t         sb_r;
  logic                        sb_rready;
  logic                        err_bad_rid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  orv64_sysbus_rd_arb #(.NUM_REQ(N), .MAX_OUTS(MO)) dut (
    .clk_i                   (clk),
    .rst_n_i                 (rst_n),
    .req_arvalid_i           (req_arvalid),
    .req_ar_i                (req_ar),
    .req_arready_o           (req_arready),
    .req_rvalid_o            (req_rvalid),
    .req_r_o                 (req_r),
    .req_rready_i            (req_rready),
    .sysbus_req_if_arvalid_o (sb_arvalid),
    .sysbus_req_if_ar_o      (sb_ar),
    .sysbus_req_if_arready_i (sb_arready),
    .sysbus_resp_if_rvalid_i (sb_rvalid),
    .sysbus_resp_if_r_i      (sb_r),
    .sysbus_resp_if_rready_o (sb_rready),
    .err_bad_rid_o           (err_bad_rid)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending-work view: how many reads each requester has in flight, who is next
  // in line, and which requester (if any) has been promised the bus.
  int  m_cnt [N] = '{default: 0};
  int  m_next    = 0;
  int  m_locked  = -1;
  bit  m_err     = 1'b0;

  int                  e_idx, e_tag, e_c;
  logic [N-1:0]        e_ardy, e_rv;
  logic                e_rrdy;
  oursring_req_if_ar_t e_ar;
  oursring_resp_if_r_t e_r;

  always @(negedge clk) begin
    e_idx = -1;
    if (rst_n) begin
      if (m_locked >= 0) e_idx = m_locked;
      else begin
        for (int k = 0; k < N; k++) begin
          e_c = (m_next + k) % N;
          if (e_idx < 0 && req_arvalid[e_c] && m_cnt[e_c] < MO) e_idx = e_c;
        end
      end
    end
    chk("m_arvalid", sb_arvalid, e_idx >= 0);
    e_ardy = '0;
    if (e_idx >= 0) begin
      e_ar = req_ar[e_idx];
      e_ar.arid = {2'(e_idx), req_ar[e_idx].arid[3:0]};
      chk("m_ar", sb_ar, e_ar);
      if (sb_arready) e_ardy[e_idx] = 1'b1;
    end
    chk("m_arready", req_arready, e_ardy);

    e_tag = int'(sb_r.rid[5:4]);
    e_r = sb_r;
    e_r.rid[5:4] = 2'b00;
    for (int i = 0; i < N; i++) chk("m_req_r", req_r[i], e_r);
    e_rv   = '0;
    e_rrdy = 1'b1;
    if (e_tag < N) begin
      e_rrdy = req_rready[e_tag];
      if (rst_n && sb_rvalid) e_rv[e_tag] = 1'b1;
    end
    chk("m_rvalid", req_rvalid, e_rv);
    chk("m_rready", sb_rready, e_rrdy);
    chk("m_err", err_bad_rid, m_err);

    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_next = 0; m_locked = -1; m_err = 1'b0;
    end else begin
      if (e_idx >= 0) begin
        if (sb_arready) begin
          m_cnt[e_idx]++;
          m_next   = (e_idx + 1) % N;
          m_locked = -1;
        end else m_locked = e_idx;
      end
      if (sb_rvalid) begin
        if (e_tag >= N) m_err = 1'b1;
        else if (req_rready[e_tag] && m_cnt[e_tag] > 0) m_cnt[e_tag]--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    req_arvalid = '0;
    req_rready  = '0;
    sb_arready  = 1'b0;
    sb_rvalid   = 1'b0;
    sb_r        = '0;
    for (int i = 0; i < N; i++) req_ar[i] = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    idle();
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic oursring_req_if_ar_t rand_ar();
    oursring_req_if_ar_t a;
    a.arid    = {2'b00, 4'($urandom)};
    a.araddr  = 40'({$urandom, $urandom});
    a.arlen   = 8'($urandom);
    a.arsize  = 3'($urandom);
    a.arburst = 2'($urandom);
    return a;
  endfunction

  initial begin
    int        rr_exp [4];
    logic [N-1:0] hs;
    bit        r_done;
    int        pick;
    ring_tid_t pend_q [$];

    rst_n = 1'b0;
    idle();
    repeat (2) cyc();

    // reset: outputs quiet even with live inputs
    req_arvalid = 3'b111; sb_arready = 1'b1; sb_rvalid = 1'b1; req_rready = 3'b111;
    #1;
    chk("rst_arvalid", sb_arvalid, 1'b0);
    chk("rst_arready", req_arready, 3'b000);
    chk("rst_rvalid", req_rvalid, 3'b000);
    cyc();
    idle();
    rst_n = 1'b1;

    // single request from req0, then its R beat
    req_arvalid = 3'b001; req_ar[0].arid = 6'h03; req_ar[0].araddr = 40'h1000; sb_arready = 1'b1;
    #1;
    chk("single_arvalid", sb_arvalid, 1'b1);
    chk("single_arid", sb_ar.arid, 6'h03);
    chk("single_arready", req_arready, 3'b001);
    cyc();
    idle();
    sb_rvalid = 1'b1; sb_r.rid = 6'h03; sb_r.rdata = 64'hDEAD_BEEF; req_rready = 3'b001;
    #1;
    chk("single_rvalid", req_rvalid, 3'b001);
    chk("single_rid", req_r[0].rid, 6'h03);
    chk("single_rready", sb_rready, 1'b1);
    cyc();

    // round-robin between req0/req1, then req1 alone
    rst_pulse();
    req_arvalid = 3'b011; req_ar[0].arid = 6'h01; req_ar[1].arid = 6'h02; sb_arready = 1'b1;
    rr_exp = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_tag", sb_ar.arid[5:4], 2'(rr_exp[k]));
      cyc();
    end
    req_arvalid = 3'b010;
    for (int k = 0; k < 2; k++) begin
      #1 chk("rr_solo_tag", sb_ar.arid[5:4], 2'd1);
      cyc();
    end

    // backpressure: grant and payload held while arready is low
    rst_pulse();
    req_arvalid = 3'b011; req_ar[0].araddr = 40'hA0; req_ar[1].araddr = 40'hB0; req_ar[1].arid = 6'h05;
    for (int k = 0; k < 4; k++) begin
      sb_arready = (k == 3);
      #1;
      chk("hold_tag", sb_ar.arid[5:4], 2'd0);
      chk("hold_addr", sb_ar.araddr, 40'hA0);
      cyc();
    end
    #1 chk("hold_next_tag", sb_ar.arid, 6'h15);
    cyc();

    // outstanding limit on req0
    rst_pulse();
    req_arvalid = 3'b001; sb_arready = 1'b1;
    repeat (4) cyc();
    req_arvalid = 3'b011;
    #1 chk("lim_tag_a", sb_ar.arid[5:4], 2'd1);
    cyc();
    #1 chk("lim_tag_b", sb_ar.arid[5:4], 2'd1);
    cyc();
    req_arvalid = 3'b000; sb_rvalid = 1'b1; sb_r.rid = 6'h00; req_rready = 3'b001;
    #1 chk("lim_r", req_rvalid, 3'b001);
    cyc();
    sb_rvalid = 1'b0; req_arvalid = 3'b011;
    #1 chk("lim_freed_tag", sb_ar.arid[5:4], 2'd0);
    cyc();

    // simultaneous inc/dec on req0 keeps count at 2 -> exactly 2 more grants fit
    rst_pulse();
    req_arvalid = 3'b001; sb_arready = 1'b1;
    repeat (2) cyc();
    sb_rvalid = 1'b1; sb_r.rid = 6'h00; req_rready = 3'b001;
    #1;
    chk("sim_arready", req_arready, 3'b001);
    chk("sim_rvalid", req_rvalid, 3'b001);
    cyc();
    sb_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("sim_arvalid", sb_arvalid, k < 2);
      cyc();
    end

    // bad tag, then reset while held
    rst_pulse();
    sb_rvalid = 1'b1; sb_r.rid = 6'h31;
    #1;
    chk("bad_rready", sb_rready, 1'b1);
    chk("bad_rvalid", req_rvalid, 3'b000);
    cyc();
    sb_rvalid = 1'b0;
    #1 chk("bad_err", err_bad_rid, 1'b1);
    cyc();
    #1 chk("bad_err_held", err_bad_rid, 1'b1);
    req_arvalid = 3'b001; sb_arready = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("hrst_arvalid", sb_arvalid, 1'b0);
    chk("hrst_arready", req_arready, 3'b000);
    cyc();
    rst_n = 1'b1; req_arvalid = 3'b010; sb_arready = 1'b1;
    #1;
    chk("hrst_err", err_bad_rid, 1'b0);
    chk("hrst_idle_tag", sb_ar.arid[5:4], 2'd1);
    cyc();
    idle();
    cyc();

    // randomized traffic; the negedge model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = req_arvalid & req_arready;
      if (sb_arvalid && sb_arready) pend_q.push_back(sb_ar.arid);
      r_done = sb_rvalid && sb_rready;
      @(posedge clk);
      #1;
      sb_arready = ($urandom_range(0, 3) != 0);
      req_rready = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        if (!req_arvalid[i] || hs[i]) begin
          req_arvalid[i] = ($urandom_range(0, 2) != 0);
          req_ar[i] = rand_ar();
        end
      end
      if (!sb_rvalid || r_done) begin
        sb_rvalid = 1'b0;
        if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          pick = int'($urandom_range(0, pend_q.size() - 1));
          sb_r.rid   = pend_q[pick];
          pend_q.delete(pick);
          sb_r.rdata = {$urandom, $urandom};
          sb_r.rresp = 2'($urandom);
          sb_r.rlast = 1'b1;
          sb_rvalid  = 1'b1;
        end
      end
    end
    idle();
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/orv64_sysbus_rd_arb.md
# orv64_sysbus_rd_arb

Read-channel arbiter that shares one sysbus AR/R port among `NUM_REQ` orv64 read requesters: the icache sysbus refill engine, the dcache uncached/refill path, and the page-table walker. It grants AR requests round-robin and tags each outgoing `arid` with the requester index. Returning R beats are routed back by that tag, and the arbiter enforces a per-requester outstanding-read limit. It sits between the per-unit sysbus masters and the core's single oursring sysbus read port.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; must be ≥2 and ≤4.
- `MAX_OUTS`, 4: maximum outstanding ARs per requester; must be ≥1 and ≤15.
- `IDX_W`, derived as `$clog2(NUM_REQ)`: width of the requester tag held in the top bits of `ring_tid_t`.

Ports:
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `req_arvalid`, in, `[NUM_REQ]`: per-requester AR valid.
- `req_ar`, in, `oursring_req_if_ar_t [NUM_REQ]`: per-requester AR payload. The top `IDX_W` bits of `arid` must be 0.
- `req_arready`, out, `[NUM_REQ]`: per-requester AR ready.
- `req_rvalid`, out, `[NUM_REQ]`: routed R valid.
- `req_r`, out, `oursring_resp_if_r_t [NUM_REQ]`: routed R payload, with the tag bits of `rid` cleared.
- `req_rready`, in, `[NUM_REQ]`: per-requester R ready.
- `sysbus_req_if_arvalid`, out, 1: downstream AR valid.
- `sysbus_req_if_ar`, out, `oursring_req_if_ar_t`: downstream AR payload.
- `sysbus_req_if_arready`, in, 1: downstream AR ready.
- `sysbus_resp_if_rvalid`, in, 1: downstream R valid.
- `sysbus_resp_if_r`, in, `oursring_resp_if_r_t`: downstream R payload.
- `sysbus_resp_if_rready`, out, 1: downstream R ready.
- `err_bad_rid`, out, 1: sticky flag. Set when an R beat arrives whose tag is ≥ `NUM_REQ`.

## Operation
- Each AR returns exactly one R beat. The outstanding count therefore changes only on handshakes:
  - increments on an AR handshake for that requester;
  - decrements on an R handshake routed to that requester.
- Eligibility: requester i is eligible when `req_arvalid[i]` is high and `outs_cnt[i] < MAX_OUTS`.
- The state machine uses `rff_state ∈ {ST_IDLE, ST_HOLD}`, plus `rff_gnt` (`IDX_W` bits) and `rff_rr_ptr` (`IDX_W` bits).

**ST_IDLE**
- Select the first eligible requester, searching from `rff_rr_ptr` upward and wrapping modulo `NUM_REQ`.
- If a requester is selected:
  - drive `sysbus_req_if_arvalid`=1 with that requester's payload and a rewritten `arid`;
  - assert `req_arready[sel] = sysbus_req_if_arready`.
- If `sysbus_req_if_arready`=1: the handshake completes, `rff_rr_ptr` ← (sel+1) mod `NUM_REQ`, and the state stays ST_IDLE.
- If `sysbus_req_if_arready`=0: `rff_gnt` ← sel, and the state goes to ST_HOLD.

**ST_HOLD**
- Present requester `rff_gnt` unconditionally. `arvalid` and the payload stay stable; eligibility is not re-evaluated.
- On `sysbus_req_if_arready`: the handshake completes, `rff_rr_ptr` ← `rff_gnt`+1 (mod), and the state returns to ST_IDLE.

**ID rewrite**
- Downstream `arid` = {requester index in the top `IDX_W` bits of `ring_tid_t`, `req_ar[i].arid` low bits}.
- All other AR fields pass through unchanged.

**R routing (combinational)**
- `tag` = top `IDX_W` bits of `sysbus_resp_if_r.rid`.
- If `tag` < `NUM_REQ`:
  - `req_rvalid[tag] = sysbus_resp_if_rvalid`;
  - `sysbus_resp_if_rready = req_rready[tag]`;
  - the other `req_rvalid` are 0.
- If `tag` ≥ `NUM_REQ`: the beat is dropped (`rready`=1), `err_bad_rid` is set, and no counter changes.
- `req_r[i]` carries the payload to every requester with the tag bits zeroed. Only the valid qualifies it.

**Counters**
- Width is `$clog2(MAX_OUTS+1)`.
- An AR handshake and an R handshake on the same requester in the same cycle leave the count unchanged.
- The count never underflows. An R handshake at count 0 leaves it at 0; verification flags this as a protocol violation.

## Timing
- Reset (`rst_n`=0 at `posedge clk`):
  - `rff_state`=ST_IDLE, `rff_rr_ptr`=0, `rff_gnt`=0, all `outs_cnt`=0, `err_bad_rid`=0.
  - While in reset, `sysbus_req_if_arvalid`=0, all `req_arready`=0 and all `req_rvalid`=0.
- AR path: 0-cycle combinational latency from `req_arvalid` to `sysbus_req_if_arvalid` in ST_IDLE. There is no registering stage.
- AXI stability: once `sysbus_req_if_arvalid` rises, it stays high with the same payload until `arready`. ST_HOLD guarantees this.
- Requester obligations:
  - requesters must hold `arvalid` until their own `arready`;
  - a requester that drops `arvalid` while held in ST_HOLD is illegal; verification checks this with an assertion.
- R path: purely combinational, 0 latency. `rready` follows the addressed requester.
- Fairness: a continuously eligible requester is granted within `NUM_REQ` AR handshakes.
- Reset mid-transaction: counts and state clear. Beats already in flight downstream are the system's responsibility; `rst_n` is global.

## Test plan
- **Single request:** req0 AR with `arid`=4'h3 and `arready`=1 → downstream `arid` tag=0, low=3, in the same cycle; `outs_cnt[0]`=1. An R beat with `rid` tag 0 → `req_rvalid[0]`=1, `req_r[0].rid`=3, count returns to 0.
- **Round-robin:** req0 and req1 both valid continuously with `arready`=1 → grants 0,1,0,1. Then with only req1 valid → grant 1 on every cycle.
- **Backpressure hold:** hold `arready`=0 for 3 cycles with both requesters valid → the same requester and payload stay stable for 4 cycles. `arready`=1 on cycle 4 → grant moves to the other requester next.
- **Outstanding limit:** `MAX_OUTS`=4; issue 4 ARs from req0 with no R → req0 is excluded and req1 is granted. One R to req0 frees it → it is granted the next cycle.
- **Simultaneous inc/dec:** req0 at count 2; AR handshake and R handshake for req0 in the same cycle → count stays 2.
- **Bad tag and reset:** with `NUM_REQ`=3, an R beat with tag 3 → `rready`=1, no `req_rvalid`, `err_bad_rid`=1 and held. Assert `rst_n`=0 for one cycle mid-ST_HOLD → all outputs at their reset values, state ST_IDLE, `err_bad_rid`=0.
